// File: rtl/bram_dp_be_fill.sv
// True-dual-port byte-enabled block RAM: port A fetch (read-only), port B load/store,
// with a fill engine that sweeps every word with FILL_VAL after reset or on request.
module bram_dp_be_fill #(
  parameter int unsigned          DATA_W      = 16,
  parameter int unsigned          ADDR_W      = 9,
  parameter int unsigned          RDW_MODE    = 0,
  parameter logic [DATA_W-1:0]    A_RST_VAL   = 16'hF000,
  parameter logic [DATA_W-1:0]    FILL_VAL    = 16'hF000,
  parameter bit                   FILL_ON_RST = 1'b1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_a_en,
  input  logic [ADDR_W-1:0]       i_a_addr,
  output logic [DATA_W-1:0]       o_a_dout,
  output logic                    o_a_valid,
  input  logic                    i_b_en,
  input  logic [DATA_W/8-1:0]     i_b_we,
  input  logic [ADDR_W-1:0]       i_b_addr,
  input  logic [DATA_W-1:0]       i_b_din,
  output logic [DATA_W-1:0]       o_b_dout,
  output logic                    o_b_valid,
  input  logic                    i_fill,
  output logic                    o_busy
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {IDLE, FILL} state_t;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   fill_cnt, fill_cnt_nx;
  logic                pend;
  logic                a_go, b_go;
  logic [DATA_W-1:0]   b_rd;
  logic [DATA_W-1:0]   mem [DEPTH];

  always_comb begin
    state_nx    = state;
    fill_cnt_nx = fill_cnt;
    a_go        = 1'b0;
    b_go        = 1'b0;
    case (state)
      IDLE: begin
        // A fill request (or the post-reset auto fill) swallows same-cycle port requests
        if (i_fill || pend) begin
          state_nx = FILL;
        end else begin
          a_go = i_a_en;
          b_go = i_b_en;
        end
      end
      FILL: begin
        fill_cnt_nx = fill_cnt + 1'b1;
        if (fill_cnt == '1) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    b_rd = '0;
    for (int unsigned k = 0; k < NB; k++) begin
      if (RDW_MODE == 1 && i_b_we[k]) b_rd[8*k +: 8] = i_b_din[8*k +: 8];
      else                            b_rd[8*k +: 8] = mem[i_b_addr][8*k +: 8];
    end
  end

  always_ff @(posedge i_clk) begin
    if (state == FILL) begin
      mem[fill_cnt] <= FILL_VAL;
    end else if (b_go) begin
      for (int unsigned k = 0; k < NB; k++) begin
        if (i_b_we[k]) mem[i_b_addr][8*k +: 8] <= i_b_din[8*k +: 8];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      fill_cnt  <= '0;
      pend      <= FILL_ON_RST;
      o_a_dout  <= A_RST_VAL;
      o_b_dout  <= '0;
      o_a_valid <= 1'b0;
      o_b_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      fill_cnt  <= fill_cnt_nx;
      pend      <= 1'b0;
      o_a_valid <= a_go;
      o_b_valid <= b_go;
      if (a_go) o_a_dout <= mem[i_a_addr];
      if (b_go) o_b_dout <= b_rd;
    end
  end

  assign o_busy = (state == FILL);

endmodule

// File: tb/tb_bram_dp_be_fill.sv
// Directed bench for bram_dp_be_fill: default 16x512 old-data build and a 32x16 new-data build.
module tb_bram_dp_be_fill;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // default build: DATA_W=16, ADDR_W=9, RDW_MODE=0, auto fill
  logic        a_en, a_valid, b_en, b_valid, fill, busy;
  logic [8:0]  a_addr, b_addr;
  logic [15:0] a_dout, b_din, b_dout;
  logic [1:0]  b_we;

  // wide build: DATA_W=32, ADDR_W=4, RDW_MODE=1, auto fill
  logic        w_a_en, w_a_valid, w_b_en, w_b_valid, w_fill, w_busy;
  logic [3:0]  w_a_addr, w_b_addr;
  logic [31:0] w_a_dout, w_b_din, w_b_dout;
  logic [3:0]  w_b_we;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  bram_dp_be_fill dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a_en(a_en), .i_a_addr(a_addr), .o_a_dout(a_dout), .o_a_valid(a_valid),
    .i_b_en(b_en), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_din(b_din),
    .o_b_dout(b_dout), .o_b_valid(b_valid),
    .i_fill(fill), .o_busy(busy)
  );

  bram_dp_be_fill #(
    .DATA_W(32), .ADDR_W(4), .RDW_MODE(1),
    .A_RST_VAL(32'hF000F000), .FILL_VAL(32'hF000F000), .FILL_ON_RST(1'b1)
  ) dut_w (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a_en(w_a_en), .i_a_addr(w_a_addr), .o_a_dout(w_a_dout), .o_a_valid(w_a_valid),
    .i_b_en(w_b_en), .i_b_we(w_b_we), .i_b_addr(w_b_addr), .i_b_din(w_b_din),
    .o_b_dout(w_b_dout), .o_b_valid(w_b_valid),
    .i_fill(w_fill), .o_busy(w_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_a(input logic [8:0] addr, input logic [15:0] exp, input string tag);
    a_en = 1'b1; a_addr = addr;
    tick();
    a_en = 1'b0;
    check({tag, "_valid"}, {31'd0, a_valid}, 32'd1);
    check(tag, {16'd0, a_dout}, {16'd0, exp});
  endtask

  task automatic wr_b(input logic [8:0] addr, input logic [15:0] din, input logic [1:0] we);
    b_en = 1'b1; b_addr = addr; b_din = din; b_we = we;
    tick();
    b_en = 1'b0; b_we = 2'b00;
  endtask

  task automatic count_busy(output int unsigned c0, output int unsigned c1);
    c0 = 0; c1 = 0;
    for (int i = 0; i < 600; i++) begin
      tick();
      c0 += busy;
      c1 += w_busy;
    end
  endtask

  initial begin
    int unsigned c0, c1, cnt;
    logic seen_valid;

    rst_n = 1'b0;
    a_en = 0; a_addr = '0; b_en = 0; b_we = '0; b_addr = '0; b_din = '0; fill = 0;
    w_a_en = 0; w_a_addr = '0; w_b_en = 0; w_b_we = '0; w_b_addr = '0; w_b_din = '0; w_fill = 0;

    #22;
    check("rst_a_dout", {16'd0, a_dout}, 32'h0000F000);
    check("rst_b_dout", {16'd0, b_dout}, 32'h0);
    check("rst_valids", {30'd0, a_valid, b_valid}, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'h0);
    check("rst_w_a_dout", w_a_dout, 32'hF000F000);

    @(posedge clk); #1;
    rst_n = 1'b1;
    count_busy(c0, c1);
    check("autofill_len", c0, 512);
    check("w_autofill_len", c1, 16);
    check("pre_read_a_dout", {16'd0, a_dout}, 32'h0000F000);

    rd_a(9'd0,   16'hF000, "fill_rd0");
    rd_a(9'd255, 16'hF000, "fill_rd255");
    rd_a(9'd511, 16'hF000, "fill_rd511");
    tick();
    check("a_valid_drop", {31'd0, a_valid}, 32'd0);

    // byte lanes
    wr_b(9'd3, 16'hABCD, 2'b11);
    check("wr_b_valid", {31'd0, b_valid}, 32'd1);
    wr_b(9'd3, 16'h1200, 2'b10);
    check("wr_hi_rdw_old", {16'd0, b_dout}, 32'h0000ABCD);
    wr_b(9'd3, 16'h0000, 2'b00);
    check("lane_merge", {16'd0, b_dout}, 32'h000012CD);

    // read-during-write and cross-port collision
    wr_b(9'd5, 16'h1111, 2'b11);
    a_en = 1'b1; a_addr = 9'd5;
    wr_b(9'd5, 16'h2222, 2'b11);
    a_en = 1'b0;
    check("rdw_b_old", {16'd0, b_dout}, 32'h00001111);
    check("collide_a_old", {16'd0, a_dout}, 32'h00001111);
    rd_a(9'd5, 16'h2222, "post_write_a");
    tick();
    check("hold_a_dout", {16'd0, a_dout}, 32'h00002222);
    check("hold_b_dout", {16'd0, b_dout}, 32'h00001111);
    check("hold_valids", {30'd0, a_valid, b_valid}, 32'd0);

    // wide build: lane write with new-data read-during-write
    w_a_en = 1'b1; w_a_addr = 4'd2;
    w_b_en = 1'b1; w_b_addr = 4'd2; w_b_din = 32'h11223344; w_b_we = 4'b0101;
    tick();
    w_a_en = 1'b0; w_b_en = 1'b0; w_b_we = '0;
    check("w_rdw_new", w_b_dout, 32'hF022F044);
    check("w_collide_a_old", w_a_dout, 32'hF000F000);
    w_a_en = 1'b1;
    tick();
    w_a_en = 1'b0;
    check("w_lane_readback", w_a_dout, 32'hF022F044);

    // requests during fill are ignored
    wr_b(9'd7, 16'h1234, 2'b11);
    wr_b(9'd7, 16'h0000, 2'b00);
    check("pre_fill_7", {16'd0, b_dout}, 32'h00001234);
    fill = 1'b1;
    b_en = 1'b1; b_addr = 9'd7; b_din = 16'hDEAD; b_we = 2'b11;
    tick();
    fill = 1'b0;
    cnt = busy;
    seen_valid = b_valid;
    for (int i = 0; i < 600 && busy; i++) begin
      tick();
      cnt += busy;
      seen_valid |= b_valid;
    end
    b_en = 1'b0; b_we = '0;
    check("fill_len", cnt, 512);
    check("fill_no_b_valid", {31'd0, seen_valid}, 32'd0);
    wr_b(9'd7, 16'h0000, 2'b00);
    check("fill_7", {16'd0, b_dout}, 32'h0000F000);
    rd_a(9'd5, 16'hF000, "fill_5");
    rd_a(9'd5, 16'hF000, "fill_5b");

    // reset mid-fill
    b_din = 16'h0000;
    wr_b(9'd5, 16'h4321, 2'b11);
    rd_a(9'd5, 16'h4321, "pre_abort_a");
    fill = 1'b1;
    tick();
    fill = 1'b0;
    for (int i = 0; i < 99; i++) tick();
    check("busy_at_100", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_a_dout", {16'd0, a_dout}, 32'h0000F000);
    check("abort_b_dout", {16'd0, b_dout}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    count_busy(c0, c1);
    check("refill_len", c0, 512);
    check("w_refill_len", c1, 16);
    rd_a(9'd5, 16'hF000, "refill_5");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bram_dp_be_fill.md
# bram_dp_be_fill

Parametrised true-dual-port, byte-lane-writable block RAM and successor to the fixed 1 KiB instruction/data memory: port A is a read-only instruction fetch port and port B a byte-enabled data load/store port. It adds configurable data width and depth, a selectable read-during-write policy, and per-port read-valid strobes. A built-in fill engine sweeps the whole array with a constant after reset or on request, so memory reaches a known state without bitstream initialisation.

## Interface
- DATA_W, 16, word width in bits; multiple of 8.
- ADDR_W, 9, word-address width; DEPTH = 2**ADDR_W words.
- NB = DATA_W/8, derived, number of byte lanes.
- RDW_MODE, 0, port-B read-during-write result: 0 = old data, 1 = new data.
- A_RST_VAL, 16'hF000, reset value of o_a_dout (fetch NOP).
- FILL_VAL, 16'hF000, word written to every address by the fill engine.
- FILL_ON_RST, 1, 1 = start a fill automatically on leaving reset.
- i_clk  in  1  single clock; all logic is on the rising edge.
- i_rst_n  in  1  reset, asynchronous assert, active-low.
- i_a_en  in  1  port A read request.
- i_a_addr  in  ADDR_W  port A word address.
- o_a_dout  out  DATA_W  port A read data, registered.
- o_a_valid  out  1  pulses for 1 cycle when o_a_dout is updated.
- i_b_en  in  1  port B access request.
- i_b_we  in  NB  port B byte-lane write enables; bit k covers din[8k+7:8k].
- i_b_addr  in  ADDR_W  port B word address.
- i_b_din  in  DATA_W  port B write data.
- o_b_dout  out  DATA_W  port B read data, registered.
- o_b_valid  out  1  pulses for 1 cycle when o_b_dout is updated.
- i_fill  in  1  single-cycle request to start a fill from IDLE.
- o_busy  out  1  high while the fill engine owns the array.

## Operation
- Storage is DEPTH x DATA_W. Memory contents are not reset by i_rst_n; only the fill engine clears them.
- FSM states:
  - IDLE: normal port service. Moves to FILL on i_fill=1, or on the first clock after reset release when FILL_ON_RST=1.
  - FILL: each cycle writes FILL_VAL at fill_cnt, then increments fill_cnt. Moves to IDLE in the cycle fill_cnt == DEPTH-1 is written. fill_cnt is ADDR_W bits and wraps to 0 on exit.
- During FILL:
  - i_a_en and i_b_en are ignored: no read, no write, no valid pulse, dout outputs hold.
  - i_fill is ignored.
- Port A read in IDLE with i_a_en=1 captures mem[i_a_addr] into o_a_dout.
- Port B access in IDLE with i_b_en=1:
  - Each lane with i_b_we[k]=1 writes i_b_din byte k.
  - o_b_dout always captures the word, including on write cycles. Written lanes show the old value when RDW_MODE=0 and the new byte when RDW_MODE=1. Unwritten lanes always show stored data.
- Cross-port collision (A reads the address B writes in the same cycle): o_a_dout returns old data regardless of RDW_MODE; the write completes normally.
- With i_x_en=0, o_x_dout holds its last value.

## Timing
- Reset values while i_rst_n=0:
  - o_a_dout = A_RST_VAL, o_b_dout = 0.
  - o_a_valid = o_b_valid = 0.
  - o_busy = 0, FSM = IDLE, fill_cnt = 0.
- Reset release:
  - FILL_ON_RST=1: o_busy rises after the first clock edge and stays high exactly DEPTH cycles.
  - FILL_ON_RST=0: block is IDLE immediately.
- Read latency is 1 cycle. A request accepted at edge n gives valid data and o_x_valid=1 after edge n. Back-to-back requests give one result per cycle.
- i_fill sampled at edge n in IDLE: o_busy=1 from after edge n through DEPTH cycles, and the last fill write lands at edge n+DEPTH. Requests at edge n+DEPTH+1 are serviced.
- A request presented in the same cycle as the accepted i_fill is dropped.
- Reset asserted mid-fill aborts the fill immediately. Array contents are partially filled. A new fill starts after release only if FILL_ON_RST=1.
- Write at edge n is visible to any port read at edge n+1.

## Test plan
- Reset, then auto-fill with DEPTH=512: o_busy high for exactly 512 cycles. Reads of addresses 0, 255 and 511 then return 16'hF000 with o_a_valid one cycle after request. Before the first read, o_a_dout = 16'hF000.
- Byte lanes: write 16'hABCD to address 3 with we=2'b11, then 16'h1200 with we=2'b10. A port-B read of address 3 returns 16'h12CD.
- Read-during-write: with mem[5]=16'h1111, B writes 16'h2222 to address 5 with we=2'b11. o_b_dout = 16'h1111 when RDW_MODE=0 and 16'h2222 when RDW_MODE=1. A same-cycle A read of address 5 returns 16'h1111.
- Requests during fill: pulse i_fill, then drive i_b_en with a write of 16'hDEAD to address 7 during FILL. o_b_valid stays 0, and mem[7] reads FILL_VAL after the fill.
- Reset mid-fill: drop i_rst_n at fill cycle 100 with FILL_ON_RST=1. Outputs take their reset values asynchronously, and after release o_busy runs a full DEPTH cycles again.
- Parametrised build with DATA_W=32 and ADDR_W=4: a write of 32'h11223344 with we=4'b0101 onto 32'hF000F000 reads back 32'hF022F044, and the fill lasts 16 cycles.
